mult_div_unit: RTL and testbench

Multi-cycle multiply/divide controller with the HI/LO register pair, sitting beside the ALU in the EX stage of the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo from EX and holds a busy window of fixed length, then commits the results to HI/LO. It exports busy indications that the hazard unit uses to stall later HI/LO instructions. It also honours an exception flush, so a squashed instruction never changes architectural state.

---
 rtl/mult_div_unit_pkg.sv | 22 ++
 rtl/mult_div_unit_if.sv | 26 ++
 rtl/mult_div_unit_md_core.sv | 58 +++++
 rtl/mult_div_unit.sv | 117 +++++++++++
 tb/tb_mult_div_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared op codes and types for the HI/LO multiply/divide unit.
// Imported by the interface, the arithmetic core and the controller.
package mult_div_unit_pkg;

   localparam int MDOP_W = 3;

   typedef enum logic [MDOP_W-1:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// EX-stage request/response bundle for the multiply/divide unit.
// master = EX/hazard side, slave = mult_div_unit.
interface mult_div_unit_if;
   import mult_div_unit_pkg::*;

   logic [MDOP_W-1:0] MdOp;
   logic              Start;
   logic              Flush;
   logic [31:0]       A;
   logic [31:0]       B;
   logic              HiLoRd;
   logic [31:0]       Out;
   logic              Busy;
   logic              MdBusy;

   modport master (
      output MdOp, Start, Flush, A, B, HiLoRd,
      input  Out, Busy, MdBusy
   );

   modport slave (
      input  MdOp, Start, Flush, A, B, HiLoRd,
      output Out, Busy, MdBusy
   );

endinterface

// File: rtl/mult_div_unit_md_core.sv
// Combinational 64-bit multiply and 32-bit divide producing pending HI/LO.
// wr=0 marks a result that must not reach HI/LO (divide by zero).
module md_core
   import mult_div_unit_pkg::*;
(
   input  md_op_e      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        wr
);

   logic signed [63:0] sprod;
   logic        [63:0] uprod;
   logic signed [31:0] squo;
   logic signed [31:0] srem;
   logic               bzero;
   logic               ovf;

   assign sprod = $signed(a) * $signed(b);
   assign uprod = {32'd0, a} * {32'd0, b};
   assign bzero = (b == 32'd0);
   // INT_MIN / -1 is pinned rather than left to the divider
   assign ovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   assign squo  = (bzero || ovf) ? 32'sd0 : $signed(a) / $signed(b);
   assign srem  = (bzero || ovf) ? 32'sd0 : $signed(a) % $signed(b);

   always_comb begin
      hi = 32'd0;
      lo = 32'd0;
      wr = 1'b0;
      unique case (op)
         MD_MULT: begin
            hi = sprod[63:32];
            lo = sprod[31:0];
            wr = 1'b1;
         end
         MD_MULTU: begin
            hi = uprod[63:32];
            lo = uprod[31:0];
            wr = 1'b1;
         end
         MD_DIV: begin
            hi = ovf ? 32'd0 : srem;
            lo = ovf ? 32'h8000_0000 : squo;
            wr = !bzero;
         end
         MD_DIVU: begin
            hi = bzero ? 32'd0 : a % b;
            lo = bzero ? 32'd0 : a / b;
            wr = !bzero;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO controller: accepts mult/div/mthi/mtlo, holds a fixed busy
// window, then commits the pending result computed at accept time.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   mult_div_unit_if.slave   bus
);

   localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W = $clog2(MAX_N + 1);
   localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   md_state_e        state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [31:0]      hi, hi_n, lo, lo_n;
   logic [31:0]      pend_hi, pend_hi_n;
   logic [31:0]      pend_lo, pend_lo_n;
   logic             pend_wr, pend_wr_n;

   md_op_e      op;
   logic        accept;
   logic        is_mthi, is_mtlo, is_mul, is_div;
   logic [31:0] core_hi, core_lo;
   logic        core_wr;

   assign op      = md_op_e'(bus.MdOp);
   assign is_mthi = (op == MD_MTHI);
   assign is_mtlo = (op == MD_MTLO);
   assign is_mul  = (op == MD_MULT) || (op == MD_MULTU);
   assign is_div  = (op == MD_DIV) || (op == MD_DIVU);
   assign accept  = bus.Start && !bus.Flush &&
                    (state == ST_IDLE) &&
                    (is_mthi || is_mtlo || is_mul || is_div);

   md_core u_core (
      .op (op),
      .a  (bus.A),
      .b  (bus.B),
      .hi (core_hi),
      .lo (core_lo),
      .wr (core_wr)
   );

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      hi_n      = hi;
      lo_n      = lo;
      pend_hi_n = pend_hi;
      pend_lo_n = pend_lo;
      pend_wr_n = pend_wr;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               unique case (1'b1)
                  is_mthi: hi_n = bus.A;
                  is_mtlo: lo_n = bus.A;
                  is_mul, is_div: begin
                     pend_hi_n = core_hi;
                     pend_lo_n = core_lo;
                     pend_wr_n = core_wr;
                     cnt_n     = is_mul ? MULT_N : DIV_N;
                     state_n   = ST_RUN;
                  end
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            // Flush is ignored here: the op already committed past M
            cnt_n = cnt - ONE;
            if (cnt == ONE) begin
               state_n = ST_IDLE;
               if (pend_wr) begin
                  hi_n = pend_hi;
                  lo_n = pend_lo;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         hi      <= hi_n;
         lo      <= lo_n;
         pend_hi <= pend_hi_n;
         pend_lo <= pend_lo_n;
         pend_wr <= pend_wr_n;
      end
   end

   assign bus.Busy   = (state == ST_RUN);
   assign bus.MdBusy = bus.Busy ||
                       (bus.Start && (op != MD_NONE));
   assign bus.Out    = bus.HiLoRd ? hi : lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus corner sequences.
module tb_mult_div_unit;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } vec_t;

   logic clk;
   logic reset_n;
   int   compared;
   int   mismatched;

   mult_div_unit_if bus();

   mult_div_unit #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(string name, logic [31:0] got,
                        logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h want 0x%08h",
                  name, got, exp);
      end
   endtask

   task automatic rd(output logic [31:0] h,
                     output logic [31:0] l);
      bus.HiLoRd = 1'b1;
      #1 h = bus.Out;
      bus.HiLoRd = 1'b0;
      #1 l = bus.Out;
   endtask

   // Called just after a negedge; returns at the negedge after the edge.
   task automatic issue(logic [2:0] op, logic [31:0] a,
                        logic [31:0] b, logic flush);
      bus.MdOp  = op;
      bus.A     = a;
      bus.B     = b;
      bus.Flush = flush;
      bus.Start = 1'b1;
      #1 check("mdbusy_start", 32'(bus.MdBusy), 32'd1);
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      bus.MdOp  = 3'd0;
      bus.Flush = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (bus.Busy && cyc < 50) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   vec_t        vec [9];
   logic [31:0] h, l;
   int          cyc;

   initial begin
      compared   = 0;
      mismatched = 0;
      vec[0] = '{3'd1, 32'hFFFFFFFF, 32'd2,
                 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
      vec[1] = '{3'd2, 32'hFFFFFFFF, 32'd2,
                 32'h00000001, 32'hFFFFFFFE, 5};
      vec[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,
                 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vec[3] = '{3'd4, 32'hFFFFFFF9, 32'd2,
                 32'h00000001, 32'h7FFFFFFC, 10};
      vec[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF,
                 32'h00000000, 32'h80000000, 10};
      vec[5] = '{3'd1, 32'd7, 32'hFFFFFFFD,
                 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
      vec[6] = '{3'd2, 32'h00010000, 32'h00010000,
                 32'h00000001, 32'h00000000, 5};
      vec[7] = '{3'd3, 32'd7, 32'hFFFFFFFE,
                 32'h00000001, 32'hFFFFFFFD, 10};
      vec[8] = '{3'd4, 32'd100, 32'd7,
                 32'h00000002, 32'h0000000E, 10};

      reset_n    = 1'b0;
      bus.MdOp   = 3'd0;
      bus.Start  = 1'b0;
      bus.Flush  = 1'b0;
      bus.A      = 32'd0;
      bus.B      = 32'd0;
      bus.HiLoRd = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      check("rst_busy", 32'(bus.Busy), 32'd0);
      check("rst_mdbusy", 32'(bus.MdBusy), 32'd0);
      rd(h, l);
      check("rst_hi", h, 32'd0);
      check("rst_lo", l, 32'd0);

      for (int i = 0; i < 9; i++) begin
         issue(vec[i].op, vec[i].a, vec[i].b, 1'b0);
         wait_idle(cyc);
         check($sformatf("v%0d_cycles", i), 32'(cyc),
               32'(vec[i].n));
         rd(h, l);
         check($sformatf("v%0d_hi", i), h, vec[i].hi);
         check($sformatf("v%0d_lo", i), l, vec[i].lo);
      end

      // divide by zero keeps HI/LO but still burns the window
      issue(3'd5, 32'h11, 32'd0, 1'b0);
      issue(3'd6, 32'h22, 32'd0, 1'b0);
      issue(3'd3, 32'd5, 32'd0, 1'b0);
      wait_idle(cyc);
      check("dz_cycles", 32'(cyc), 32'd10);
      rd(h, l);
      check("dz_hi", h, 32'h11);
      check("dz_lo", l, 32'h22);
      issue(3'd4, 32'd9, 32'd0, 1'b0);
      wait_idle(cyc);
      check("dzu_cycles", 32'(cyc), 32'd10);
      rd(h, l);
      check("dzu_hi", h, 32'h11);
      check("dzu_lo", l, 32'h22);

      // flushed start is dropped
      issue(3'd1, 32'd3, 32'd4, 1'b1);
      check("flush_busy", 32'(bus.Busy), 32'd0);
      check("flush_mdbusy", 32'(bus.MdBusy), 32'd0);
      rd(h, l);
      check("flush_hi", h, 32'h11);
      check("flush_lo", l, 32'h22);

      // mthi while busy is ignored; Out keeps old value in RUN
      issue(3'd5, 32'h77, 32'd0, 1'b0);
      issue(3'd1, 32'd2, 32'd3, 1'b0);
      issue(3'd5, 32'd5, 32'd0, 1'b0);
      rd(h, l);
      check("run_busy", 32'(bus.Busy), 32'd1);
      check("run_old_hi", h, 32'h77);
      check("run_old_lo", l, 32'h22);
      wait_idle(cyc);
      check("mthi_busy_cycles", 32'(cyc), 32'd4);
      rd(h, l);
      check("mthi_busy_hi", h, 32'd0);
      check("mthi_busy_lo", l, 32'd6);

      // async reset in cycle 3 of a div
      issue(3'd5, 32'h33, 32'd0, 1'b0);
      issue(3'd4, 32'd100, 32'd7, 1'b0);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(bus.Busy), 32'd0);
      rd(h, l);
      check("mid_rst_hi", h, 32'd0);
      check("mid_rst_lo", l, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      check("post_rst_busy", 32'(bus.Busy), 32'd0);
      rd(h, l);
      check("post_rst_hi", h, 32'd0);
      check("post_rst_lo", l, 32'd0);

      // mtlo then back-to-back mults
      issue(3'd6, 32'hABCD, 32'd0, 1'b0);
      rd(h, l);
      check("mtlo_lo", l, 32'hABCD);
      issue(3'd1, 32'd3, 32'd5, 1'b0);
      wait_idle(cyc);
      check("b2b_a_cycles", 32'(cyc), 32'd5);
      rd(h, l);
      check("b2b_a_lo", l, 32'd15);
      issue(3'd1, 32'd4, 32'd5, 1'b0);
      check("b2b_b_busy", 32'(bus.Busy), 32'd1);
      wait_idle(cyc);
      check("b2b_b_cycles", 32'(cyc), 32'd5);
      rd(h, l);
      check("b2b_b_hi", h, 32'd0);
      check("b2b_b_lo", l, 32'd20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
